// File: rtl/traffic_sensor_conditioner.sv
// Conditions two asynchronous loop-detector levels into debounced demand flags and vehicle counts.
// Defining SENSOR_FAULT_EN adds stuck-detector monitoring with fail-safe demand on fault_a/fault_b.
module traffic_sensor_conditioner #(
  parameter int DEB_CYCLES   = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int CNT_W        = 8,
  parameter int STUCK_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_a,
  input  logic             raw_b,
  input  logic             clr_cnt,
  output logic             Ta,
  output logic             Tb,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             fault_a,
  output logic             fault_b
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

`ifdef SENSOR_FAULT_EN
  localparam int STK_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_CYCLES);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUAL_ON,
    S_PRESENT,
    S_QUAL_OFF,
    S_HOLD
  } state_e;

  logic [1:0]       raw_vec;
  logic [1:0]       t_vec;
  logic [1:0]       fault_vec;
  logic [CNT_W-1:0] cnt_vec [2];

  assign raw_vec = {raw_b, raw_a};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic              sync1_q, sync2_q;
    state_e            state_q, state_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              from_hold_q, from_hold_d;
    logic              t_q, t_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              fault_q, fault_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= raw_vec[ch];
        sync2_q <= sync1_q;
      end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
      state_d     = state_q;
      deb_d       = deb_q;
      hold_d      = hold_q;
      from_hold_d = from_hold_q;
      accept      = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sync2_q) begin
            state_d     = S_QUAL_ON;
            deb_d       = DEB_ONE;
            from_hold_d = 1'b0;
          end
        end
        S_QUAL_ON: begin
          if (!sync2_q) begin
            deb_d = '0;
            if (from_hold_q) begin
              state_d = S_HOLD;
              hold_d  = HOLD_MAX;
            end else begin
              state_d = S_IDLE;
            end
          end else if (deb_q == DEB_LAST) begin
            state_d = S_PRESENT;
            deb_d   = '0;
            accept  = 1'b1;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        S_PRESENT: begin
          if (!sync2_q) begin
            state_d = S_QUAL_OFF;
            deb_d   = DEB_ONE;
          end
        end
        S_QUAL_OFF: begin
          if (sync2_q) begin
            state_d = S_PRESENT;
            deb_d   = '0;
          end else if (deb_q == DEB_LAST) begin
            state_d = S_HOLD;
            deb_d   = '0;
            hold_d  = HOLD_MAX;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (sync2_q) begin
            state_d     = S_QUAL_ON;
            deb_d       = DEB_ONE;
            hold_d      = '0;
            from_hold_d = 1'b1;
          end else if (hold_q == HOLD_ONE) begin
            state_d = S_IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          deb_d   = '0;
          hold_d  = '0;
        end
      endcase
    end

    // Demand is carried through QUAL_ON so re-qualifying from HOLD never drops it.
    always_comb begin
      t_d = 1'b1;
      if (state_d == S_IDLE) begin
        t_d = 1'b0;
      end else if (state_d == S_QUAL_ON) begin
        t_d = t_q;
      end
      if (fault_d) begin
        t_d = 1'b1;
      end
    end

    always_comb begin
      if (clr_cnt) begin
        cnt_d = accept ? CNT_ONE : '0;
      end else if (accept && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q     <= S_IDLE;
        deb_q       <= '0;
        hold_q      <= '0;
        from_hold_q <= 1'b0;
        t_q         <= 1'b0;
        cnt_q       <= '0;
      end else begin
        state_q     <= state_d;
        deb_q       <= deb_d;
        hold_q      <= hold_d;
        from_hold_q <= from_hold_d;
        t_q         <= t_d;
        cnt_q       <= cnt_d;
      end
    end

`ifdef SENSOR_FAULT_EN
    logic [STK_W-1:0] stuck_q, stuck_d;

    always_comb begin
      stuck_d = '0;
      if ((state_q == S_PRESENT) && (state_d == S_PRESENT)) begin
        stuck_d = (stuck_q == STK_MAX) ? stuck_q : stuck_q + 1'b1;
      end
      fault_d = fault_q | (stuck_d == STK_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stuck_q <= '0;
        fault_q <= 1'b0;
      end else begin
        stuck_q <= stuck_d;
        fault_q <= fault_d;
      end
    end
`else
    assign fault_q = 1'b0;
    assign fault_d = 1'b0;
`endif

    assign t_vec[ch]     = t_q;
    assign fault_vec[ch] = fault_q;
    assign cnt_vec[ch]   = cnt_q;
  end

  assign Ta      = t_vec[0];
  assign Tb      = t_vec[1];
  assign cnt_a   = cnt_vec[0];
  assign cnt_b   = cnt_vec[1];
  assign fault_a = fault_vec[0];
  assign fault_b = fault_vec[1];

endmodule
